hex_input: RTL

Switch-and-pushbutton hex entry block: the input-side counterpart of the 7-segment display path. The operator sets a hex digit on four slide switches and presses ENTER. Two presses assemble one byte, high nibble first, which is then offered to the consumer (CPU I/O port or test harness) over a valid/ack handshake. A live `entry` bus feeds the display path so that digits appear as they are typed.

---
 rtl/hex_input.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/hex_input.sv
`default_nettype none
// ============================================================================
// Module      : hex_input
// Description : Hex entry from four slide switches and two pushbuttons.
//               The operator sets a digit on the switches and presses ENTER;
//               two presses build one byte, high nibble first. The byte is
//               offered to a consumer over a valid/ack handshake. CLEAR drops
//               the byte being typed. The live entry bus feeds the display.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_input #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       key_enter_n,
  input  logic       key_clear_n,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [7:0] entry,
  output logic [1:0] digit_count
);

  // The debounce counter only needs to reach DEBOUNCE_CYCLES-1: the sample
  // that would bring it to DEBOUNCE_CYCLES is the one that flips the level.
  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  // Key indices into the per-key vectors.
  localparam int c_KEY_ENTER = 0;
  localparam int c_KEY_CLEAR = 1;
  localparam int c_NUM_KEYS  = 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronizers. Keys idle high (released) so they reset to 1;
  // the switch bus resets to 0.
  // --------------------------------------------------------------------------
  logic [3:0]            sw_meta_q;
  logic [3:0]            sw_sync_q;
  logic [c_NUM_KEYS-1:0] key_meta_q;
  logic [c_NUM_KEYS-1:0] key_sync_q;
  logic [c_NUM_KEYS-1:0] w_key_raw;

  assign w_key_raw[c_KEY_ENTER] = key_enter_n;
  assign w_key_raw[c_KEY_CLEAR] = key_clear_n;

  // Bring the asynchronous switch and key levels into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q  <= 4'h0;
      sw_sync_q  <= 4'h0;
      key_meta_q <= '1;
      key_sync_q <= '1;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= w_key_raw;
      key_sync_q <= key_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Per-key debounce and press detection. A new level is accepted only after
  // DEBOUNCE_CYCLES consecutive synchronized samples disagree with the current
  // debounced level; any agreeing sample restarts the count. The press pulse
  // is registered alongside the level update, so it is high exactly in the
  // cycle after the debounced level falls.
  // --------------------------------------------------------------------------
  logic [c_NUM_KEYS-1:0] w_press;

  genvar gi;
  generate
    for (gi = 0; gi < c_NUM_KEYS; gi++) begin : g_key
      logic [c_CNT_W-1:0] cnt_q;
      logic [c_CNT_W-1:0] cnt_d;
      logic               deb_q;
      logic               deb_d;
      logic               press_q;
      logic               press_d;

      // Count disagreeing samples and flip the level when the run is long enough.
      always_comb begin
        cnt_d   = '0;
        deb_d   = deb_q;
        press_d = 1'b0;
        if (key_sync_q[gi] != deb_q) begin
          if (cnt_q == c_CNT_LAST) begin
            deb_d   = key_sync_q[gi];
            // Only a released-to-pressed transition (1 -> 0) is a press.
            press_d = ~key_sync_q[gi];
          end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
          end
        end
      end

      // Debounce state: released level, empty count, no pulse out of reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q   <= '0;
          deb_q   <= 1'b1;
          press_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          deb_q   <= deb_d;
          press_q <= press_d;
        end
      end

      assign w_press[gi] = press_q;
    end
  endgenerate

  logic w_enter;
  logic w_clear;

  assign w_enter = w_press[c_KEY_ENTER];
  assign w_clear = w_press[c_KEY_CLEAR];

  // --------------------------------------------------------------------------
  // Entry state machine. CLEAR has priority over everything, which also makes
  // a simultaneous ENTER get dropped and a simultaneous ack irrelevant.
  // ENTER in FULL is ignored so a pending byte is never overwritten.
  // --------------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic [7:0] entry_q;
  logic [7:0] entry_d;
  logic [7:0] data_out_q;
  logic [7:0] data_out_d;

  // State register plus the entry and data_out holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      entry_q    <= 8'h00;
      data_out_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      data_out_q <= data_out_d;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    data_out_d = data_out_q;
    if (w_clear) begin
      // data_out is deliberately left alone: only the typed entry is dropped.
      state_d = S_EMPTY;
      entry_d = 8'h00;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_enter) begin
            entry_d = {sw_sync_q, 4'h0};
            state_d = S_HALF;
          end
        end
        S_HALF: begin
          if (w_enter) begin
            entry_d    = {entry_q[7:4], sw_sync_q};
            data_out_d = {entry_q[7:4], sw_sync_q};
            state_d    = S_FULL;
          end
        end
        S_FULL: begin
          // entry and data_out stay visible after the byte is taken.
          if (data_ack) begin
            state_d = S_EMPTY;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  // Decode the digit count from the state.
  always_comb begin
    digit_count = 2'd0;
    case (state_q)
      S_HALF:  digit_count = 2'd1;
      S_FULL:  digit_count = 2'd2;
      default: digit_count = 2'd0;
    endcase
  end

  assign data_valid = (state_q == S_FULL);
  assign data_out   = data_out_q;
  assign entry      = entry_q;

endmodule
`default_nettype wire
